// File: rtl/h80bus_arbiter.sv
// Two-master round-robin arbiter for the h80 bus with a per-grant burst limit.
// Optional statistics counters are enabled with `define H80BUS_ARBITER_STATS_EN.
module h80bus_arbiter #(
    parameter int unsigned BUS_ADDR_WIDTH = 16,
    parameter int unsigned BUS_CMD_WIDTH  = 3,
    parameter int unsigned BUS_DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      m0_ce_n,
    input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
    output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
    output logic                      m0_wait_n,
    input  logic                      m1_ce_n,
    input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
    output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
    output logic                      m1_wait_n,
    output logic                      s_ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] s_addr,
    output logic [BUS_CMD_WIDTH-1:0]  s_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] s_data_,
    input  logic                      s_wait_n,
    output logic [1:0]                grant
`ifdef H80BUS_ARBITER_STATS_EN
    ,
    output logic [31:0]               stat_xfer0,
    output logic [31:0]               stat_xfer1,
    output logic [31:0]               stat_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    state_t              other_state;
    logic                last_grant_q, last_grant_d;   // 0 = M0 owned last, 1 = M1
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                req0, req1;
    logic                own_req, other_req;
    logic                at_limit;
    logic                xfer0, xfer1;
    logic [BUS_DATA_WIDTH-1:0] wdata_sel;

    assign req0 = ~m0_ce_n;
    assign req1 = ~m1_ce_n;

    assign own_req     = (state_q == GNT1) ? req1 : req0;
    assign other_req   = (state_q == GNT1) ? req0 : req1;
    assign other_state = (state_q == GNT1) ? GNT0 : GNT1;
    // Completing transfer number MAX_BURST (or later, once saturated) ends the grant.
    assign at_limit    = (burst_cnt_q >= CNT_LIMIT);

    assign xfer0 = (state_q == GNT0) && req0 && s_wait_n;
    assign xfer1 = (state_q == GNT1) && req1 && s_wait_n;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req) begin
                    state_d      = other_req ? other_state : IDLE;
                    last_grant_d = (state_q == GNT1);
                    burst_cnt_d  = '0;
                end else if (s_wait_n) begin
                    if (other_req && at_limit) begin
                        state_d      = other_state;
                        last_grant_d = (state_q == GNT1);
                        burst_cnt_d  = '0;
                    end else if (burst_cnt_q != CNT_MAX) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus muxing follows the registered owner; the owner's pins pass straight through.
    always_comb begin
        s_ce_n    = 1'b1;
        s_addr    = '0;
        s_cmd     = '0;
        wdata_sel = '0;
        m0_wait_n = 1'b0;
        m1_wait_n = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        grant     = 2'b00;
        unique case (state_q)
            GNT0: begin
                s_ce_n    = m0_ce_n;
                s_addr    = m0_addr;
                s_cmd     = m0_cmd;
                wdata_sel = m0_wdata;
                m0_wait_n = s_wait_n;
                m0_rdata  = s_data_;
                grant     = 2'b01;
            end
            GNT1: begin
                s_ce_n    = m1_ce_n;
                s_addr    = m1_addr;
                s_cmd     = m1_cmd;
                wdata_sel = m1_wdata;
                m1_wait_n = s_wait_n;
                m1_rdata  = s_data_;
                grant     = 2'b10;
            end
            default: ;
        endcase
    end

    assign s_data_ = (!s_ce_n && !s_cmd[0]) ? wdata_sel : {BUS_DATA_WIDTH{1'bz}};

`ifdef H80BUS_ARBITER_STATS_EN
    logic stall_cycle;
    assign stall_cycle = (req0 && state_q != GNT0) || (req1 && state_q != GNT1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_xfer0 <= '0;
            stat_xfer1 <= '0;
            stat_stall <= '0;
        end else begin
            if (xfer0)       stat_xfer0 <= stat_xfer0 + 32'd1;
            if (xfer1)       stat_xfer1 <= stat_xfer1 + 32'd1;
            if (stall_cycle) stat_stall <= stat_stall + 32'd1;
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer0 ^ xfer1;
`endif

endmodule

// File: tb/tb_h80bus_arbiter.sv
// Directed self-checking bench for h80bus_arbiter with a word-addressed memory model.
// Stats checks are compiled in when H80BUS_ARBITER_STATS_EN is defined.
module tb_h80bus_arbiter;

    localparam int AW = 16;
    localparam int CW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          m0_ce_n = 1'b1, m1_ce_n = 1'b1;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [CW-1:0] m0_cmd = '0, m1_cmd = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_wait_n, m1_wait_n;
    logic          s_ce_n;
    logic [AW-1:0] s_addr;
    logic [CW-1:0] s_cmd;
    wire  [DW-1:0] s_data;
    logic          s_wait_n = 1'b1;
    logic [1:0]    grant;
`ifdef H80BUS_ARBITER_STATS_EN
    logic [31:0]   stat_xfer0, stat_xfer1, stat_stall;
`endif

    always #5 clk = ~clk;

    h80bus_arbiter #(
        .BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW), .MAX_BURST(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_ce_n(m0_ce_n), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_wait_n(m0_wait_n),
        .m1_ce_n(m1_ce_n), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_wait_n(m1_wait_n),
        .s_ce_n(s_ce_n), .s_addr(s_addr), .s_cmd(s_cmd), .s_data_(s_data),
        .s_wait_n(s_wait_n), .grant(grant)
`ifdef H80BUS_ARBITER_STATS_EN
        , .stat_xfer0(stat_xfer0), .stat_xfer1(stat_xfer1), .stat_stall(stat_stall)
`endif
    );

    // Memory model: word index = addr[10:1]; combinational read, write on completion edge.
    logic [DW-1:0] mem [0:1023];
    logic          pre_en = 1'b0;
    logic [9:0]    pre_idx = '0;
    logic [DW-1:0] pre_val = '0;

    assign s_data = (!s_ce_n && s_cmd[0]) ? mem[s_addr[10:1]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (!s_ce_n && !s_cmd[0] && s_wait_n) mem[s_addr[10:1]] <= s_data;
    end

    int checks = 0;
    int passes = 0;

    logic [1:0] obs_grant [0:31];
    logic       obs_w0    [0:31];
    logic       obs_w1    [0:31];
    logic       drv_ce0   [0:31];
    logic       drv_ce1   [0:31];

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        m0_ce_n  = 1'b1;
        m1_ce_n  = 1'b1;
        s_wait_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [DW-1:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Write-only masters: M0 writes A000+i to base0+2i, M1 writes B000+i to base1+2i.
    // A master advances when it sees wait_n=1 with its ce_n low (completion at the next edge).
    task automatic run_masters(input int cnt0, input int cnt1,
                               input logic [AW-1:0] base0, input logic [AW-1:0] base1,
                               input int stall_at, input int stall_len, input int ncyc);
        int i0 = 0;
        int i1 = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m0_ce_n  = (i0 < cnt0) ? 1'b0 : 1'b1;
            m0_addr  = base0 + AW'(2 * i0);
            m0_cmd   = 3'b000;
            m0_wdata = 16'hA000 + DW'(i0);
            m1_ce_n  = (i1 < cnt1) ? 1'b0 : 1'b1;
            m1_addr  = base1 + AW'(2 * i1);
            m1_cmd   = 3'b000;
            m1_wdata = 16'hB000 + DW'(i1);
            s_wait_n = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 : 1'b1;
            #1;
            obs_grant[c] = grant;
            obs_w0[c]    = m0_wait_n;
            obs_w1[c]    = m1_wait_n;
            drv_ce0[c]   = m0_ce_n;
            drv_ce1[c]   = m1_ce_n;
            if (!m0_ce_n && m0_wait_n) i0++;
            if (!m1_ce_n && m1_wait_n) i1++;
        end
        m0_ce_n  = 1'b1;
        m1_ce_n  = 1'b1;
        s_wait_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_ce_n = 1'b0;
        m1_ce_n = 1'b0;
        #12;
        checks++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else passes++;
        checks++; if (s_ce_n !== 1'b1) $display("FAIL rst_s_ce_n: got %b want 1", s_ce_n); else passes++;
        checks++; if (s_addr !== 16'h0 || s_cmd !== 3'b0)
            $display("FAIL rst_s_addr_cmd: got %h/%b want 0000/000", s_addr, s_cmd); else passes++;
        checks++; if (m0_wait_n !== 1'b0 || m1_wait_n !== 1'b0)
            $display("FAIL rst_wait_n: got %b%b want 00", m0_wait_n, m1_wait_n); else passes++;
        checks++; if (m0_rdata !== 16'h0 || m1_rdata !== 16'h0)
            $display("FAIL rst_rdata: got %h/%h want 0000/0000", m0_rdata, m1_rdata); else passes++;
`ifdef H80BUS_ARBITER_STATS_EN
        checks++; if (stat_xfer0 !== 0 || stat_xfer1 !== 0 || stat_stall !== 0)
            $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", stat_xfer0, stat_xfer1, stat_stall);
        else passes++;
`endif
        m0_ce_n = 1'b1;
        m1_ce_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        preload(10'h010, 16'hBEEF);
        @(negedge clk);
        m0_ce_n = 1'b0; m0_addr = 16'h0020; m0_cmd = 3'b001;
        #1;
        checks++; if (grant !== 2'b00) $display("FAIL rd_idle_grant: got %b want 00", grant); else passes++;
        checks++; if (m0_wait_n !== 1'b0) $display("FAIL rd_idle_wait: got %b want 0", m0_wait_n); else passes++;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) $display("FAIL rd_gnt_grant: got %b want 01", grant); else passes++;
        checks++; if (s_ce_n !== 1'b0 || s_addr !== 16'h0020)
            $display("FAIL rd_slave_pins: got %b/%h want 0/0020", s_ce_n, s_addr); else passes++;
        checks++; if (m0_wait_n !== 1'b1) $display("FAIL rd_gnt_wait: got %b want 1", m0_wait_n); else passes++;
        checks++; if (m0_rdata !== 16'hBEEF) $display("FAIL rd_data: got %h want BEEF", m0_rdata); else passes++;
        @(negedge clk);
        m0_ce_n = 1'b1;
        #1;
        checks++; if (grant !== 2'b01) $display("FAIL rd_release_grant: got %b want 01", grant); else passes++;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) $display("FAIL rd_back_idle: got %b want 00", grant); else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        m0_ce_n = 1'b0; m0_addr = 16'h0040; m0_cmd = 3'b000; m0_wdata = 16'h1111;
        m1_ce_n = 1'b0; m1_addr = 16'h0042; m1_cmd = 3'b000; m1_wdata = 16'h2222;
        #1;
        checks++; if (grant !== 2'b00) $display("FAIL sim_idle: got %b want 00", grant); else passes++;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) $display("FAIL sim_first_m0: got %b want 01", grant); else passes++;
        checks++; if (m0_wait_n !== 1'b1 || m1_wait_n !== 1'b0)
            $display("FAIL sim_waits: got %b%b want 10", m0_wait_n, m1_wait_n); else passes++;
        checks++; if (s_data !== 16'h1111) $display("FAIL sim_wdata: got %h want 1111", s_data); else passes++;
        @(negedge clk);
        m0_ce_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b10) $display("FAIL sim_handoff_m1: got %b want 10", grant); else passes++;
        checks++; if (s_ce_n !== 1'b0 || s_addr !== 16'h0042)
            $display("FAIL sim_zero_bubble: got %b/%h want 0/0042", s_ce_n, s_addr); else passes++;
        @(negedge clk);
        m1_ce_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) $display("FAIL sim_back_idle: got %b want 00", grant); else passes++;
        checks++; if (mem[10'h020] !== 16'h1111 || mem[10'h021] !== 16'h2222)
            $display("FAIL sim_mem: got %h/%h want 1111/2222", mem[10'h020], mem[10'h021]); else passes++;
    endtask

    task automatic test_burst_limit();
        logic [1:0] exp_g;
        int         exp_stall;
        do_reset();
        run_masters(10, 8, 16'h0100, 16'h0200, 99, 0, 21);
        exp_stall = 0;
        for (int c = 0; c < 21; c++) begin
            if      (c == 0)  exp_g = 2'b00;
            else if (c <= 4)  exp_g = 2'b01;
            else if (c <= 8)  exp_g = 2'b10;
            else if (c <= 12) exp_g = 2'b01;
            else if (c <= 16) exp_g = 2'b10;
            else if (c <= 19) exp_g = 2'b01;
            else              exp_g = 2'b00;
            checks++;
            if (obs_grant[c] !== exp_g)
                $display("FAIL burst_grant[%0d]: got %b want %b", c, obs_grant[c], exp_g);
            else passes++;
            if ((!drv_ce0[c] && exp_g != 2'b01) || (!drv_ce1[c] && exp_g != 2'b10)) exp_stall++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mem[10'h080 + 10'(i)] !== 16'hA000 + 16'(i))
                $display("FAIL burst_mem_m0[%0d]: got %h want %h", i, mem[10'h080 + 10'(i)], 16'hA000 + 16'(i));
            else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[10'h100 + 10'(i)] !== 16'hB000 + 16'(i))
                $display("FAIL burst_mem_m1[%0d]: got %h want %h", i, mem[10'h100 + 10'(i)], 16'hB000 + 16'(i));
            else passes++;
        end
`ifdef H80BUS_ARBITER_STATS_EN
        checks++; if (stat_xfer0 !== 32'd10) $display("FAIL stat_xfer0: got %0d want 10", stat_xfer0); else passes++;
        checks++; if (stat_xfer1 !== 32'd8) $display("FAIL stat_xfer1: got %0d want 8", stat_xfer1); else passes++;
        checks++; if (stat_stall !== 32'(exp_stall))
            $display("FAIL stat_stall: got %0d want %0d", stat_stall, exp_stall); else passes++;
`else
        if (exp_stall < 0) $display("unexpected stall model value %0d", exp_stall);
`endif
    endtask

    task automatic test_stall();
        logic [1:0] exp_g;
        do_reset();
        run_masters(5, 1, 16'h0300, 16'h0380, 4, 3, 13);
        for (int c = 0; c < 13; c++) begin
            if      (c == 0)  exp_g = 2'b00;
            else if (c <= 7)  exp_g = 2'b01;
            else if (c <= 9)  exp_g = 2'b10;
            else if (c <= 11) exp_g = 2'b01;
            else              exp_g = 2'b00;
            checks++;
            if (obs_grant[c] !== exp_g)
                $display("FAIL stall_grant[%0d]: got %b want %b", c, obs_grant[c], exp_g);
            else passes++;
        end
        for (int c = 4; c < 7; c++) begin
            checks++;
            if (obs_w0[c] !== 1'b0 || obs_w1[c] !== 1'b0)
                $display("FAIL stall_wait[%0d]: got %b%b want 00", c, obs_w0[c], obs_w1[c]);
            else passes++;
        end
        checks++; if (mem[10'h183] !== 16'hA003 || mem[10'h1C0] !== 16'hB000)
            $display("FAIL stall_mem: got %h/%h want A003/B000", mem[10'h183], mem[10'h1C0]); else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        preload(10'h200, 16'h5A5A);
        @(negedge clk);
        m0_ce_n = 1'b0; m0_addr = 16'h0400; m0_cmd = 3'b000; m0_wdata = 16'h1234;
        @(negedge clk); #1;
        checks++; if (s_ce_n !== 1'b0 || grant !== 2'b01)
            $display("FAIL arst_pre: got %b/%b want 0/01", s_ce_n, grant); else passes++;
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (s_ce_n !== 1'b1) $display("FAIL arst_s_ce_n: got %b want 1", s_ce_n); else passes++;
        checks++; if (grant !== 2'b00) $display("FAIL arst_grant: got %b want 00", grant); else passes++;
        checks++; if (m0_wait_n !== 1'b0 || m1_wait_n !== 1'b0)
            $display("FAIL arst_wait: got %b%b want 00", m0_wait_n, m1_wait_n); else passes++;
        @(negedge clk);
        m0_ce_n = 1'b1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) $display("FAIL arst_idle: got %b want 00", grant); else passes++;
        checks++; if (mem[10'h200] !== 16'h5A5A)
            $display("FAIL arst_no_write: got %h want 5A5A", mem[10'h200]); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_burst_limit();
        test_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
